// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
//   Pipeline stall/flush controller for the 5-stage 16-bit core. It takes the
//   hazard unit's load-use stall and the branch, memory-busy and halt events.
//   From these it drives the PC and pipeline-register write enables, the IF/ID
//   flush and the ID/EX bubble.
//
//   Internal state: RUN / LDGUARD / MEMWAIT / HALTED FSM and a memory-wait
//   counter. The sticky memErr flag is set when that counter times out.
//
// Parameters
//   MEM_TIMEOUT  consecutive memStall cycles before memErr + halt (1..65535)
//   CNT_W        width of the optional performance counters
//
// Ports
//   clk           core clock, rising edge
//   rst           asynchronous active-low reset
//   ldStall       load-use hazard (ID instruction needs the load in EX)
//   branchTaken   EX-stage branch/jump resolved taken
//   memStall      instruction/data memory busy; freeze the whole pipe
//   haltWB        HALT instruction in WB
//   pcWriteEn     PC write enable
//   ifidWriteEn   IF/ID write enable
//   ifidFlush     load NOP into IF/ID
//   idexBubble    load NOP into ID/EX
//   exmemWriteEn  EX/MEM and MEM/WB write enable
//   halted        core halted (sticky until reset)
//   memErr        memory-wait timeout seen (sticky until reset)
//   stallCycles   cycles with pcWriteEn=0 while not halted (STALL_PERF_EN)
//   flushCount    number of ifidFlush cycles (STALL_PERF_EN)
//
// Build option
//   STALL_PERF_EN  when defined, builds the saturating stallCycles/flushCount
//                  counters; otherwise both outputs are tied to zero.
// -----------------------------------------------------------------------------
module pipe_stall_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ldStall,
  input  logic             branchTaken,
  input  logic             memStall,
  input  logic             haltWB,
  output logic             pcWriteEn,
  output logic             ifidWriteEn,
  output logic             ifidFlush,
  output logic             idexBubble,
  output logic             exmemWriteEn,
  output logic             halted,
  output logic             memErr,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushCount
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    S_RUN,
    S_LDGUARD,
    S_MEMWAIT,
    S_HALTED
  } state_e;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    mem_err_d    = mem_err_q;
    pcWriteEn    = 1'b1;
    ifidWriteEn  = 1'b1;
    exmemWriteEn = 1'b1;
    ifidFlush    = 1'b0;
    idexBubble   = 1'b0;

    if (!rst) begin
      // Hold the pipe frozen and filled with NOPs while reset is asserted.
      pcWriteEn    = 1'b0;
      ifidWriteEn  = 1'b0;
      exmemWriteEn = 1'b0;
      ifidFlush    = 1'b1;
      idexBubble   = 1'b1;
    end else if (state_q == S_HALTED) begin
      pcWriteEn    = 1'b0;
      ifidWriteEn  = 1'b0;
      exmemWriteEn = 1'b0;
    end else if (memStall) begin
      pcWriteEn    = 1'b0;
      ifidWriteEn  = 1'b0;
      exmemWriteEn = 1'b0;
      state_d      = S_MEMWAIT;
      // The counter can never already sit at WAIT_MAX here, because reaching
      // it sends the FSM to HALTED. The guard only keeps it from wrapping.
      if (wait_cnt_q != WAIT_MAX) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
      if (wait_cnt_d == WAIT_MAX) begin
        mem_err_d = 1'b1;
        state_d   = S_HALTED;
      end
    end else begin
      // A released MEMWAIT is handled exactly like RUN in this cycle.
      wait_cnt_d = '0;
      if (branchTaken) begin
        ifidFlush  = 1'b1;
        idexBubble = 1'b1;
        state_d    = S_RUN;
      end else if (ldStall && (state_q != S_LDGUARD)) begin
        pcWriteEn   = 1'b0;
        ifidWriteEn = 1'b0;
        idexBubble  = 1'b1;
        state_d     = S_LDGUARD;
      end else begin
        state_d = S_RUN;
      end
      if (haltWB) begin
        state_d = S_HALTED;
      end
    end
  end

  assign halted = (state_q == S_HALTED);
  assign memErr = mem_err_q;

`ifdef STALL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q != S_HALTED) begin
      if (!pcWriteEn && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (ifidFlush && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + 1'b1;
      end
    end
  end

  assign stallCycles = stall_cnt_q;
  assign flushCount  = flush_cnt_q;
`else
  assign stallCycles = '0;
  assign flushCount  = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

  localparam int TO = 12;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ldStall, branchTaken, memStall, haltWB;
  logic          pcWriteEn, ifidWriteEn, ifidFlush, idexBubble, exmemWriteEn;
  logic          halted, memErr;
  logic [CW-1:0] stallCycles, flushCount;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, kept at the level of the rules themselves.
  bit m_halt, m_err, m_guard;
  int m_wait, m_stall, m_flush;

  pipe_stall_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ldStall(ldStall), .branchTaken(branchTaken),
    .memStall(memStall), .haltWB(haltWB), .pcWriteEn(pcWriteEn),
    .ifidWriteEn(ifidWriteEn), .ifidFlush(ifidFlush), .idexBubble(idexBubble),
    .exmemWriteEn(exmemWriteEn), .halted(halted), .memErr(memErr),
    .stallCycles(stallCycles), .flushCount(flushCount)
  );

  always #5 clk = ~clk;

  // {pcWriteEn, ifidWriteEn, ifidFlush, idexBubble, exmemWriteEn, halted, memErr}
  function automatic logic [6:0] got();
    return {pcWriteEn, ifidWriteEn, ifidFlush, idexBubble, exmemWriteEn, halted, memErr};
  endfunction

  function automatic logic [6:0] exp_out();
    if (m_halt)                   return {5'b00000, 1'b1, m_err};
    else if (memStall)            return {5'b00000, 1'b0, m_err};
    else if (branchTaken)         return {5'b11111, 1'b0, m_err};
    else if (ldStall && !m_guard) return {5'b00011, 1'b0, m_err};
    else                          return {5'b11001, 1'b0, m_err};
  endfunction

  function automatic int exp_stall();
`ifdef STALL_PERF_EN
    return m_stall;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_flush();
`ifdef STALL_PERF_EN
    return m_flush;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_halt = 0; m_err = 0; m_guard = 0; m_wait = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_clock();
    logic [6:0] e;
    e = exp_out();
    if (!m_halt) begin
      if (!e[6] && m_stall < (1 << CW) - 1) m_stall++;
      if (e[4] && m_flush < (1 << CW) - 1) m_flush++;
      if (memStall) begin
        m_wait++;
        m_guard = 0;
        if (m_wait == TO) begin
          m_err  = 1;
          m_halt = 1;
        end
      end else begin
        m_wait  = 0;
        m_guard = ldStall && !branchTaken && !m_guard;
        if (haltWB) m_halt = 1;
      end
    end
  endtask

  // Phase convention: every task starts and ends 1 time unit after a posedge.
  task automatic drive(input logic [3:0] v);
    {ldStall, branchTaken, memStall, haltWB} = v;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic assert_reset();
    rst = 1'b0;
    {ldStall, branchTaken, memStall, haltWB} = 4'b0000;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    assert_reset();
    n_tests++;
    if (got() !== 7'b0011000) begin
      n_fail++; $display("FAIL reset_out: got %b want %b", got(), 7'b0011000);
    end
    n_tests++;
    if (stallCycles !== '0 || flushCount !== '0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stallCycles, flushCount);
    end
    release_reset();
    drive(4'b0000);
    n_tests++;
    if (got() !== 7'b1100100) begin
      n_fail++; $display("FAIL reset_first_run: got %b want %b", got(), 7'b1100100);
    end
    tick();
  endtask

  task automatic test_ldstall();
    logic [3:0] seq [6] = '{4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b0000};
    logic [6:0] want [6] = '{7'b0001100, 7'b1100100, 7'b0001100, 7'b1100100, 7'b0001100, 7'b1100100};
    for (int i = 0; i < 6; i++) begin
      drive(seq[i]);
      n_tests++;
      if (got() !== want[i] || got() !== exp_out()) begin
        n_fail++; $display("FAIL ldstall[%0d]: got %b want %b", i, got(), want[i]);
      end
      tick();
    end
  endtask

  task automatic test_branch_ld();
    drive(4'b1100);
    n_tests++;
    if (got() !== 7'b1111100) begin
      n_fail++; $display("FAIL branch_ld: got %b want %b", got(), 7'b1111100);
    end
    tick();
    // Back in RUN, so a fresh ldStall must stall.
    drive(4'b1000);
    n_tests++;
    if (got() !== exp_out()) begin
      n_fail++; $display("FAIL branch_ld_after: got %b want %b", got(), exp_out());
    end
    tick();
  endtask

  task automatic test_memwait();
    for (int i = 0; i < 10; i++) begin
      drive(4'b0010);
      n_tests++;
      if (got() !== 7'b0000000) begin
        n_fail++; $display("FAIL memwait[%0d]: got %b want %b", i, got(), 7'b0000000);
      end
      tick();
    end
    drive(4'b0100);
    n_tests++;
    if (got() !== 7'b1111100) begin
      n_fail++; $display("FAIL memwait_release: got %b want %b", got(), 7'b1111100);
    end
    tick();
    // One short of the timeout, released by a load-use stall honoured at once.
    for (int i = 0; i < TO; i++) begin
      drive((i == TO - 1) ? 4'b1000 : 4'b0010);
      n_tests++;
      if (got() !== exp_out()) begin
        n_fail++; $display("FAIL memwait_edge[%0d]: got %b want %b", i, got(), exp_out());
      end
      tick();
    end
    drive(4'b0000);
    n_tests++;
    if (memErr !== 1'b0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL memwait_noerr: got err=%b halt=%b want 0/0", memErr, halted);
    end
    tick();
  endtask

  task automatic test_timeout();
    for (int i = 0; i < TO; i++) begin
      drive(4'b0010);
      n_tests++;
      if (got() !== exp_out()) begin
        n_fail++; $display("FAIL timeout[%0d]: got %b want %b", i, got(), exp_out());
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(4'b0100);
      n_tests++;
      if (got() !== 7'b0000011) begin
        n_fail++; $display("FAIL timeout_sticky[%0d]: got %b want %b", i, got(), 7'b0000011);
      end
      tick();
    end
    assert_reset();
    n_tests++;
    if (got() !== 7'b0011000) begin
      n_fail++; $display("FAIL timeout_reset: got %b want %b", got(), 7'b0011000);
    end
    release_reset();
  endtask

  task automatic test_halt();
    drive(4'b0101);
    n_tests++;
    if (got() !== 7'b1111100) begin
      n_fail++; $display("FAIL halt_cycle: got %b want %b", got(), 7'b1111100);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive((i == 1) ? 4'b1100 : 4'b0000);
      n_tests++;
      if (got() !== 7'b0000010) begin
        n_fail++; $display("FAIL halted[%0d]: got %b want %b", i, got(), 7'b0000010);
      end
      tick();
    end
    assert_reset();
    n_tests++;
    if (halted !== 1'b0 || got() !== 7'b0011000) begin
      n_fail++; $display("FAIL halt_reset: got %b want %b", got(), 7'b0011000);
    end
    release_reset();
    // memStall outranks haltWB: no halt.
    drive(4'b0011);
    tick();
    drive(4'b0000);
    n_tests++;
    if (halted !== 1'b0) begin
      n_fail++; $display("FAIL halt_masked: got halted=%b want 0", halted);
    end
    tick();
  endtask

  task automatic test_perf();
    logic [3:0] seq [10] = '{4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b1000,
                             4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000};
    assert_reset();
    release_reset();
    for (int i = 0; i < 10; i++) begin
      drive(seq[i]);
      tick();
    end
    n_tests++;
    if (int'(stallCycles) != exp_stall() || int'(flushCount) != exp_flush()) begin
      n_fail++; $display("FAIL perf: got %0d/%0d want %0d/%0d",
                         stallCycles, flushCount, exp_stall(), exp_flush());
    end
`ifdef STALL_PERF_EN
    n_tests++;
    if (stallCycles !== CW'(3) || flushCount !== CW'(2)) begin
      n_fail++; $display("FAIL perf_const: got %0d/%0d want 3/2", stallCycles, flushCount);
    end
`endif
  endtask

  task automatic test_random();
    int burst = 0;
    logic [3:0] v;
    assert_reset();
    release_reset();
    for (int i = 0; i < 800; i++) begin
      if (m_halt && $urandom_range(0, 3) == 0) begin
        n_tests++;
        if (int'(stallCycles) != exp_stall() || int'(flushCount) != exp_flush()) begin
          n_fail++; $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d", i,
                             stallCycles, flushCount, exp_stall(), exp_flush());
        end
        assert_reset();
        release_reset();
      end else begin
        if (burst > 0) begin
          v[1] = 1'b1;
          burst--;
        end else begin
          v[1] = ($urandom_range(0, 99) < 15);
          if ($urandom_range(0, 99) < 4) burst = TO - 2 + int'($urandom_range(0, 3));
        end
        v[3] = ($urandom_range(0, 99) < 35);
        v[2] = ($urandom_range(0, 99) < 20);
        v[0] = ($urandom_range(0, 99) < 2);
        drive(v);
        n_tests++;
        if (got() !== exp_out()) begin
          n_fail++; $display("FAIL rand[%0d] in=%b: got %b want %b", i, v, got(), exp_out());
        end
        tick();
      end
    end
    n_tests++;
    if (int'(stallCycles) != exp_stall() || int'(flushCount) != exp_flush()) begin
      n_fail++; $display("FAIL rand_cnt_end: got %0d/%0d want %0d/%0d",
                         stallCycles, flushCount, exp_stall(), exp_flush());
    end
  endtask

  initial begin
    rst = 1'b0;
    {ldStall, branchTaken, memStall, haltWB} = 4'b0000;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_ldstall();
    test_branch_ld();
    test_memwait();
    test_timeout();
    test_halt();
    test_perf();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
